reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single register-bank write port (RegWrite / WriteRegister / WriteData) between several writers:
  - requester 0: pipeline writeback, fixed highest priority;
  - requesters 1..NREQ-1: syscall/$a0 loader, debug injector and similar, served round-robin among themselves.
- Registers one winning write per cycle into an issue stage that drives the bank; the bank commits it on the following falling edge.
- Exposes the in-flight write for forwarding so readers never miss a granted-but-uncommitted value.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 is fixed-priority.
- MAX_WAIT, 8, cycles a low-priority request may lose to requester 0 before the starvation guard forces it (only with the optional feature).

Ports:
- iCLK  in  1  clock; bank writes on its negedge.
- iRST_n  in  1  asynchronous active-low reset.
- iHold  in  1  freeze: no new grants while high.
- iReqValid  in  NREQ  per-requester write request.
- iReqReg  in  NREQ*5  destination register per requester; requester i occupies bits [5i+4:5i].
- iReqData  in  NREQ*32  write data per requester; requester i occupies bits [32i+31:32i].
- oReqReady  out  NREQ  one-hot grant; transfer occurs when valid && ready.
- oRegWrite  out  1  to the bank's RegWrite input.
- oWriteRegister  out  5  to the bank's WriteRegister input.
- oWriteData  out  32  to the bank's WriteData input.
- iFwdReg  in  5  register number being read.
- oFwdHit  out  1  the issue stage holds a pending write to iFwdReg.
- oFwdData  out  32  data of that pending write.

Behaviour:
- Reset (async, iRST_n=0):
  - oRegWrite=0, oWriteRegister=0, oWriteData=0, oReqReady=0, oFwdHit=0;
  - round-robin pointer=1, starve counter=0.
- Grant (combinational, from current inputs and registered state):
  - If iHold=1 or iRST_n=0: no grant.
  - Else if iReqValid[0]=1: grant requester 0.
  - Else: grant the first valid requester among 1..NREQ-1, searching upward from the pointer and wrapping past NREQ-1 to 1.
  - oReqReady is one-hot or zero. A requester must hold valid, reg and data stable until it sees ready.
- Issue stage (posedge iCLK):
  - On a transfer, capture reg and data. oRegWrite=1 unless reg==0.
  - A write to $0 is accepted and consumed, but oRegWrite=0.
  - With no transfer: oRegWrite=0; oWriteRegister and oWriteData hold their last values.
  - Latency: grant in cycle N → bank inputs valid in cycle N+1 → committed on the negedge of cycle N+1.
  - Throughput: one write per cycle; no backpressure from the bank.
- Pointer:
  - After a grant to k≥1, pointer = k+1, wrapping to 1 after NREQ-1.
  - Unchanged on a grant to 0 or on no grant.
- Forwarding:
  - oFwdHit = oRegWrite && (oWriteRegister==iFwdReg).
  - oFwdData = oWriteData.
  - Both are purely from registered state and iFwdReg.
- iHold asserted mid-stream:
  - A write already in the issue stage still issues in that cycle.
  - From the next cycle onward oRegWrite=0 until grants resume.
- Reset during a pending write: the write is discarded; the bank sees oRegWrite=0 immediately (async).

Optional Feature:
- Macro: REG_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle requester 0 is granted while any requester 1..NREQ-1 is valid.
  - It clears when a low-priority grant occurs, or when no low-priority requester is valid.
  - When the counter equals MAX_WAIT, the next arbitration grants the round-robin winner instead of requester 0. Requester 0 waits one cycle and the counter clears.
  - Counter width is clog2(MAX_WAIT+1).
- Undefined: strict priority for requester 0; no counter logic is present.

Decomposition:
- Package reg_arb_pkg:
  - REG_W=5, DATA_W=32, REG_ZERO=5'd0;
  - issue-stage struct type {valid, reg, data}.
- Sub-module rr_arb: round-robin one-hot selector over requesters 1..NREQ-1, including pointer update. The top level adds the requester-0 priority, the starvation override and the issue stage.

Test Plan:
- Reset, then requester 1 writes reg 8 = 32'hDEADBEEF. Ready[1] is high in cycle N; cycle N+1 shows oRegWrite=1, oWriteRegister=8, oWriteData=DEADBEEF. Reset mid-hold drops oRegWrite to 0 at once.
- Requesters 0, 1 and 2 all valid every cycle (guard undefined). Grants go 0,0,0,…; no grant ever reaches 1 or 2. Drop req0: grants alternate 1,2,1,2.
- Requester 2 writes reg 0 = 32'h1234. Ready[2]=1, and in the following cycle oRegWrite=0.
- Requester 0 writes reg 5 = 32'hA5A5A5A5 with iFwdReg=5. In the next cycle oFwdHit=1 and oFwdData=A5A5A5A5. With iFwdReg=6, oFwdHit=0.
- iHold=1 while requesters 0 and 1 are valid. oReqReady=0 and oRegWrite=0 from the second held cycle onward. Release: req0 is granted first.
- Guard defined, MAX_WAIT=4, requesters 0 and 1 continuously valid. Pattern is 0,0,0,0,1 repeating, with the counter returning to 0 after each grant to requester 1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared widths and issue-stage record for the register write arbiter.
package reg_arb_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic valid;
    logic [REG_W-1:0] regno;
    logic [DATA_W-1:0] data;
  } issue_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester, bank and forwarding signals of the register write arbiter.
interface reg_write_arbiter_if import reg_arb_pkg::*; #(parameter int NREQ = 3) ();
  logic iHold;
  logic [NREQ-1:0] iReqValid;
  logic [NREQ*REG_W-1:0] iReqReg;
  logic [NREQ*DATA_W-1:0] iReqData;
  logic [NREQ-1:0] oReqReady;
  logic oRegWrite;
  logic [REG_W-1:0] oWriteRegister;
  logic [DATA_W-1:0] oWriteData;
  logic [REG_W-1:0] iFwdReg;
  logic oFwdHit;
  logic [DATA_W-1:0] oFwdData;
  modport master (
    output iHold, iReqValid, iReqReg, iReqData, iFwdReg,
    input oReqReady, oRegWrite, oWriteRegister, oWriteData, oFwdHit, oFwdData
  );
  modport slave (
    input iHold, iReqValid, iReqReg, iReqData, iFwdReg,
    output oReqReady, oRegWrite, oWriteRegister, oWriteData, oFwdHit, oFwdData
  );
endinterface

// File: rtl/reg_write_arbiter_rr_arb.sv
// rr_arb: round-robin one-hot selector over requesters 1..NREQ-1 with its own pointer.
module rr_arb #(parameter int NREQ = 3) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:1] req,
  input  logic            take,
  output logic [NREQ-1:1] grant
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, ptr_nxt;
  int j;
  // Scan downward so the slot closest to the pointer is assigned last and wins.
  always_comb begin
    grant = '0;
    j = 1;
    for (int i = NREQ-2; i >= 0; i--) begin
      j = (int'(ptr) - 1 + i) % (NREQ-1) + 1;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
      end
    end
  end
  always_comb begin
    ptr_nxt = ptr;
    for (int k = 1; k < NREQ; k++)
      if (grant[k]) ptr_nxt = (k == NREQ-1) ? PW'(1) : PW'(k + 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= PW'(1);
    else if (take) ptr <= ptr_nxt;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-bank write port; requester 0 fixed priority, others round-robin.
// Optional starvation guard for requesters 1..NREQ-1 enabled by defining REG_ARB_STARVE_GUARD_EN.
module reg_write_arbiter import reg_arb_pkg::*; #(
  parameter int NREQ = 3,
  parameter int MAX_WAIT = 8
) (
  input logic iCLK,
  input logic iRST_n,
  reg_write_arbiter_if.slave bus
);
  if (NREQ < 2 || NREQ > 8 || MAX_WAIT < 1) $error("reg_write_arbiter: NREQ must be 2..8 and MAX_WAIT >= 1");
  logic [NREQ-1:1] rr_grant;
  logic [NREQ-1:0] ready;
  logic ok, low_any, force_rr;
  issue_t sel, iss;
  assign ok = !bus.iHold && iRST_n;
  assign low_any = |bus.iReqValid[NREQ-1:1];
  assign ready = !ok ? '0 : (bus.iReqValid[0] && !force_rr) ? NREQ'(1) : {rr_grant, 1'b0};
  rr_arb #(.NREQ(NREQ)) u_rr (
    .clk(iCLK),
    .rst_n(iRST_n),
    .req(bus.iReqValid[NREQ-1:1]),
    .take(|ready[NREQ-1:1]),
    .grant(rr_grant)
  );
`ifdef REG_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] starve;
  assign force_rr = (starve == CW'(MAX_WAIT)) && low_any;
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) starve <= '0;
    else if (ready[0] && low_any) starve <= starve + 1'b1;
    else if (|ready[NREQ-1:1] || !low_any) starve <= '0;
`else
  assign force_rr = 1'b0;
`endif
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (ready[i]) begin
        sel.regno = bus.iReqReg[REG_W*i +: REG_W];
        sel.data = bus.iReqData[DATA_W*i +: DATA_W];
        sel.valid = bus.iReqReg[REG_W*i +: REG_W] != REG_ZERO;
      end
  end
  // Writes to $0 are consumed like any other but never raise RegWrite.
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) iss <= '0;
    else if (|ready) iss <= sel;
    else iss.valid <= 1'b0;
  assign bus.oReqReady = ready;
  assign bus.oRegWrite = iss.valid;
  assign bus.oWriteRegister = iss.regno;
  assign bus.oWriteData = iss.data;
  assign bus.oFwdHit = iss.valid && (iss.regno == bus.iFwdReg);
  assign bus.oFwdData = iss.data;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: randomized requesters checked against a transaction-level arbitration model.
module tb_reg_write_arbiter;
  localparam int NREQ = 3;
  localparam int MW = 4;
`ifdef REG_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  reg_write_arbiter_if #(.NREQ(NREQ)) bus ();
  reg_write_arbiter #(.NREQ(NREQ), .MAX_WAIT(MW)) dut (.iCLK(clk), .iRST_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [NREQ-1:0] pend;
  logic [4:0] preg [NREQ];
  logic [31:0] pdat [NREQ];
  int rate [NREQ];
  int hold_pct;
  logic hold;
  logic [4:0] fsel;
  int ptr, cnt;
  logic mv;
  logic [4:0] mr;
  logic [31:0] md;
  int vectors = 0, miscompares = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    bus.iHold = hold;
    bus.iReqValid = pend;
    bus.iFwdReg = fsel;
    for (int i = 0; i < NREQ; i++) begin
      bus.iReqReg[5*i +: 5] = preg[i];
      bus.iReqData[32*i +: 32] = pdat[i];
    end
  endtask
  function automatic int rr_pick();
    for (int k = 0; k < NREQ-1; k++) begin
      int idx;
      idx = (ptr - 1 + k) % (NREQ-1) + 1;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction
  task automatic model_reset();
    ptr = 1; cnt = 0; mv = 1'b0; mr = '0; md = '0;
  endtask
  // One cycle: new stimulus after the falling edge, checks, then advance the model to the next rising edge.
  task automatic step(input int fwd);
    int g, lw;
    logic low_any;
    logic [NREQ-1:0] er;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && $urandom_range(0, 99) < rate[i]) begin
        pend[i] = 1'b1;
        preg[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        pdat[i] = $urandom;
      end
    hold = $urandom_range(0, 99) < hold_pct;
    fsel = (fwd >= 0) ? 5'(fwd) : ($urandom_range(0, 1) ? mr : 5'($urandom));
    drive();
    #1;
    check("regwrite", 32'(bus.oRegWrite), 32'(mv));
    check("wreg", 32'(bus.oWriteRegister), 32'(mr));
    check("wdata", bus.oWriteData, md);
    check("fwd_hit", 32'(bus.oFwdHit), 32'(mv && mr == fsel));
    check("fwd_data", bus.oFwdData, md);
    lw = rr_pick();
    low_any = |pend[NREQ-1:1];
    g = hold ? -1 : (pend[0] && !(GUARD && cnt == MW && lw > 0)) ? 0 : lw;
    er = (g >= 0) ? NREQ'(1) << g : '0;
    check("ready", 32'(bus.oReqReady), 32'(er));
    if (g > 0) ptr = (g == NREQ-1) ? 1 : g + 1;
    if (GUARD) begin
      if (g == 0 && low_any) cnt++;
      else if (g > 0 || !low_any) cnt = 0;
    end
    if (g >= 0) begin
      mv = preg[g] != 5'd0; mr = preg[g]; md = pdat[g]; pend[g] = 1'b0;
    end else mv = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; pend = '0; hold = 1'b0; hold_pct = 0; fsel = '0;
    for (int i = 0; i < NREQ; i++) begin rate[i] = 0; preg[i] = '0; pdat[i] = '0; end
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.oReqReady), 32'd0);
    check("rst_regwrite", 32'(bus.oRegWrite), 32'd0);
    check("rst_wreg", 32'(bus.oWriteRegister), 32'd0);
    check("rst_wdata", bus.oWriteData, 32'd0);
    check("rst_fwd_hit", 32'(bus.oFwdHit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pend[1] = 1'b1; preg[1] = 5'd8; pdat[1] = 32'hDEADBEEF;
    step(-1);
    @(negedge clk);
    hold = 1'b1;
    drive();
    #1;
    check("first_regwrite", 32'(bus.oRegWrite), 32'd1);
    check("first_wreg", 32'(bus.oWriteRegister), 32'd8);
    check("first_wdata", bus.oWriteData, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("async_rst_regwrite", 32'(bus.oRegWrite), 32'd0);
    check("async_rst_ready", 32'(bus.oReqReady), 32'd0);
    check("async_rst_wdata", bus.oWriteData, 32'd0);
    model_reset();
    pend = '0; hold = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) rate[i] = 100;
    repeat (20) step(-1);
    rate[0] = 0;
    repeat (12) step(-1);
    for (int i = 0; i < NREQ; i++) rate[i] = 0;
    repeat (4) step(-1);
    pend[2] = 1'b1; preg[2] = 5'd0; pdat[2] = 32'h1234;
    step(-1);
    step(-1);
    pend[0] = 1'b1; preg[0] = 5'd5; pdat[0] = 32'hA5A5A5A5;
    step(-1);
    step(5);
    pend[0] = 1'b1; preg[0] = 5'd5; pdat[0] = 32'hA5A5A5A5;
    step(-1);
    step(6);
    pend[0] = 1'b1; pend[1] = 1'b1; preg[1] = 5'd9; pdat[1] = 32'h0BADF00D;
    hold_pct = 100;
    repeat (3) step(-1);
    hold_pct = 0;
    repeat (3) step(-1);
    rate[0] = 100; rate[1] = 100;
    repeat (15) step(-1);
    rate[0] = 40; rate[1] = 30; rate[2] = 30; hold_pct = 10;
    repeat (400) step(-1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
